// File: rtl/pulse_to_level_if.sv
// Pulse/level handshake bundle: pulse requests and hold setting in, reconstructed level and status out.
interface pulse_to_level_if #(
  parameter int HOLD_W = 8
);
  logic              p_pulse;
  logic              n_pulse;
  logic [HOLD_W-1:0] hold_cfg;
  logic              clr_err;
  logic              level_out;
  logic              busy;
  logic              pend_valid;
  logic              conflict_err;
  logic [15:0]       edge_cnt;

  modport master (
    output p_pulse, n_pulse, hold_cfg, clr_err,
    input  level_out, busy, pend_valid, conflict_err, edge_cnt
  );

  modport slave (
    input  p_pulse, n_pulse, hold_cfg, clr_err,
    output level_out, busy, pend_valid, conflict_err, edge_cnt
  );
endinterface

// File: rtl/pulse_to_level.sv
// Rebuilds a level from rise/fall pulses with a minimum hold time; an opposite
// request during a hold is queued and applied once the level has lasted hold_cfg+1 cycles.
module pulse_to_level #(
  parameter int   HOLD_W     = 8,
  parameter logic INIT_LEVEL = 1'b0
) (
  input logic           clk,
  input logic           rst,
  pulse_to_level_if.slave bus
);

  typedef enum logic [1:0] {
    STEADY_LOW  = 2'd0,
    HOLD_LOW    = 2'd1,
    STEADY_HIGH = 2'd2,
    HOLD_HIGH   = 2'd3
  } state_t;

  localparam state_t RESET_STATE = INIT_LEVEL ? STEADY_HIGH : STEADY_LOW;

  state_t            state, state_nxt;
  logic [HOLD_W-1:0] cnt, cnt_nxt;
  logic              pend, pend_nxt;
  logic              level, level_nxt;
  logic              err, err_nxt;
  logic [15:0]       edges, edges_nxt;

  logic conflict, p_ok, n_ok, away, back, pend_eval;

  assign conflict = bus.p_pulse & bus.n_pulse;
  assign p_ok     = bus.p_pulse & ~bus.n_pulse;
  assign n_ok     = bus.n_pulse & ~bus.p_pulse;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RESET_STATE;
      cnt   <= '0;
      pend  <= 1'b0;
      level <= INIT_LEVEL;
      err   <= 1'b0;
      edges <= 16'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      pend  <= pend_nxt;
      level <= level_nxt;
      err   <= err_nxt;
      edges <= edges_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pend_nxt  = pend;
    level_nxt = level;
    away      = 1'b0;
    back      = 1'b0;
    pend_eval = pend;
    case (state)
      STEADY_LOW: begin
        if (p_ok) begin
          level_nxt = 1'b1;
          cnt_nxt   = bus.hold_cfg;
          state_nxt = (bus.hold_cfg != '0) ? HOLD_HIGH : STEADY_HIGH;
        end
      end
      STEADY_HIGH: begin
        if (n_ok) begin
          level_nxt = 1'b0;
          cnt_nxt   = bus.hold_cfg;
          state_nxt = (bus.hold_cfg != '0) ? HOLD_LOW : STEADY_LOW;
        end
      end
      default: begin
        away = (state == HOLD_HIGH) ? n_ok : p_ok;
        back = (state == HOLD_HIGH) ? p_ok : n_ok;
        // This cycle's pulse updates the queue before expiry is decided.
        if (away) begin
          pend_eval = 1'b1;
        end else if (back) begin
          pend_eval = 1'b0;
        end
        // A queued flip waits one cycle longer than a plain return to steady,
        // so the level always lasts hold_cfg+1 cycles before it flips.
        if (pend_eval && (cnt == '0)) begin
          level_nxt = ~level;
          cnt_nxt   = bus.hold_cfg;
          pend_nxt  = 1'b0;
          if (bus.hold_cfg != '0) begin
            state_nxt = level ? HOLD_LOW : HOLD_HIGH;
          end else begin
            state_nxt = level ? STEADY_LOW : STEADY_HIGH;
          end
        end else if (!pend_eval && (cnt <= HOLD_W'(1))) begin
          state_nxt = level ? STEADY_HIGH : STEADY_LOW;
          cnt_nxt   = '0;
          pend_nxt  = 1'b0;
        end else begin
          cnt_nxt  = cnt - 1'b1;
          pend_nxt = pend_eval;
        end
      end
    endcase

    if (conflict) begin
      err_nxt = 1'b1;
    end else if (bus.clr_err) begin
      err_nxt = 1'b0;
    end else begin
      err_nxt = err;
    end

    edges_nxt = (level_nxt != level) ? edges + 16'd1 : edges;
  end

  always_comb begin
    bus.busy         = (state == HOLD_LOW) || (state == HOLD_HIGH);
    bus.level_out    = level;
    bus.pend_valid   = pend;
    bus.conflict_err = err;
    bus.edge_cnt     = edges;
  end

endmodule

// File: tb/tb_pulse_to_level.sv
// Directed table-driven bench for pulse_to_level plus hand-written reset and wrap sequences.
module tb_pulse_to_level;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  pulse_to_level_if #(.HOLD_W(8)) bus ();

  pulse_to_level #(.HOLD_W(8), .INIT_LEVEL(1'b0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        p;
    logic        n;
    logic        clr;
    logic        rs;
    logic [7:0]  hold;
    logic        lvl;
    logic        busy;
    logic        pend;
    logic        err;
    logic [15:0] ecnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic p, input logic n, input logic clr, input logic rs,
                     input logic [7:0] hold, input logic lvl, input logic busy,
                     input logic pend, input logic err, input logic [15:0] ecnt);
    vec_t v;
    v.p = p; v.n = n; v.clr = clr; v.rs = rs; v.hold = hold;
    v.lvl = lvl; v.busy = busy; v.pend = pend; v.err = err; v.ecnt = ecnt;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic p, input logic n, input logic clr, input logic rs,
                       input logic [7:0] hold);
    bus.p_pulse  = p;
    bus.n_pulse  = n;
    bus.clr_err  = clr;
    rst          = rs;
    bus.hold_cfg = hold;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int idx, input logic lvl, input logic busy,
                       input logic pend, input logic err, input logic [15:0] ecnt);
    logic [19:0] got, exp;
    got = {bus.level_out, bus.busy, bus.pend_valid, bus.conflict_err, bus.edge_cnt};
    exp = {lvl, busy, pend, err, ecnt};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s[%0d] got lvl=%b busy=%b pend=%b err=%b edges=%0d want lvl=%b busy=%b pend=%b err=%b edges=%0d",
               name, idx, got[19], got[18], got[17], got[16], got[15:0],
               lvl, busy, pend, err, ecnt);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    bus.p_pulse = 0; bus.n_pulse = 0; bus.clr_err = 0; bus.hold_cfg = 0; rst = 1;

    //   p  n  clr rst hold   lvl busy pend err edges
    add(0, 0, 0, 1, 8'd0,  0, 0, 0, 0, 16'd0);
    add(0, 0, 0, 0, 8'd0,  0, 0, 0, 0, 16'd0);
    add(1, 0, 0, 0, 8'd0,  1, 0, 0, 0, 16'd1);
    add(0, 0, 0, 0, 8'd0,  1, 0, 0, 0, 16'd1);
    add(1, 0, 0, 0, 8'd0,  1, 0, 0, 0, 16'd1);
    add(0, 1, 0, 0, 8'd0,  0, 0, 0, 0, 16'd2);
    add(0, 1, 0, 0, 8'd0,  0, 0, 0, 0, 16'd2);
    // hold 4, fall queued right after the rise, applied after 5 high cycles
    add(1, 0, 0, 0, 8'd4,  1, 1, 0, 0, 16'd3);
    add(0, 1, 0, 0, 8'd4,  1, 1, 1, 0, 16'd3);
    add(0, 1, 0, 0, 8'd4,  1, 1, 1, 0, 16'd3);
    add(0, 0, 0, 0, 8'd4,  1, 1, 1, 0, 16'd3);
    add(0, 0, 0, 0, 8'd4,  1, 1, 1, 0, 16'd3);
    add(0, 0, 0, 0, 8'd4,  0, 1, 0, 0, 16'd4);
    // mid-hold hold_cfg change must not stretch the low hold
    add(0, 0, 0, 0, 8'd9,  0, 1, 0, 0, 16'd4);
    add(0, 0, 0, 0, 8'd9,  0, 1, 0, 0, 16'd4);
    add(0, 0, 0, 0, 8'd9,  0, 1, 0, 0, 16'd4);
    add(0, 0, 0, 0, 8'd9,  0, 0, 0, 0, 16'd4);
    // glitch cancelled inside the hold
    add(1, 0, 0, 0, 8'd4,  1, 1, 0, 0, 16'd5);
    add(0, 1, 0, 0, 8'd4,  1, 1, 1, 0, 16'd5);
    add(1, 0, 0, 0, 8'd4,  1, 1, 0, 0, 16'd5);
    add(0, 0, 0, 0, 8'd4,  1, 1, 0, 0, 16'd5);
    add(0, 0, 0, 0, 8'd4,  1, 0, 0, 0, 16'd5);
    add(0, 1, 0, 0, 8'd0,  0, 0, 0, 0, 16'd6);
    // conflicts and error clearing
    add(1, 1, 0, 0, 8'd0,  0, 0, 0, 1, 16'd6);
    add(0, 0, 0, 0, 8'd0,  0, 0, 0, 1, 16'd6);
    add(0, 0, 1, 0, 8'd0,  0, 0, 0, 0, 16'd6);
    add(1, 1, 1, 0, 8'd0,  0, 0, 0, 1, 16'd6);
    add(0, 0, 1, 0, 8'd0,  0, 0, 0, 0, 16'd6);
    // fall arriving in the last plain-hold cycle is queued, applied one edge later
    add(1, 0, 0, 0, 8'd2,  1, 1, 0, 0, 16'd7);
    add(0, 0, 0, 0, 8'd2,  1, 1, 0, 0, 16'd7);
    add(0, 1, 0, 0, 8'd2,  1, 1, 1, 0, 16'd7);
    add(0, 0, 0, 0, 8'd0,  0, 0, 0, 0, 16'd8);
    // symmetric cancel in HOLD_LOW
    add(1, 0, 0, 0, 8'd0,  1, 0, 0, 0, 16'd9);
    add(0, 1, 0, 0, 8'd3,  0, 1, 0, 0, 16'd10);
    add(1, 0, 0, 0, 8'd3,  0, 1, 1, 0, 16'd10);
    add(0, 1, 0, 0, 8'd3,  0, 1, 0, 0, 16'd10);
    add(0, 0, 0, 0, 8'd3,  0, 0, 0, 0, 16'd10);

    foreach (vecs[i]) begin
      drive(vecs[i].p, vecs[i].n, vecs[i].clr, vecs[i].rs, vecs[i].hold);
      check("vec", i, vecs[i].lvl, vecs[i].busy, vecs[i].pend, vecs[i].err, vecs[i].ecnt);
    end

    // reset mid-hold discards the queued fall; pulse during reset ignored
    drive(1, 0, 0, 0, 8'd6);  check("rst_hold", 0, 1, 1, 0, 0, 16'd11);
    drive(0, 1, 0, 0, 8'd6);  check("rst_hold", 1, 1, 1, 1, 0, 16'd11);
    drive(1, 1, 0, 0, 8'd6);  check("rst_hold", 2, 1, 1, 1, 1, 16'd11);
    drive(1, 0, 0, 1, 8'd6);  check("rst_hold", 3, 0, 0, 0, 0, 16'd0);
    for (int k = 0; k < 10; k++) begin
      drive(0, 0, 0, 0, 8'd6);
      check("rst_after", k, 0, 0, 0, 0, 16'd0);
    end

    // 65536 accepted alternating pulses wrap the edge counter
    for (int k = 0; k < 65535; k++) begin
      drive(k[0] == 1'b0, k[0] == 1'b1, 0, 0, 8'd0);
    end
    check("wrap_pre", 0, 1, 0, 0, 0, 16'hFFFF);
    drive(0, 1, 0, 0, 8'd0);
    check("wrap", 0, 0, 0, 0, 0, 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
